truth_table_sequencer: RTL and testbench

- Sequences a combinational N_IN-input logic function through every input combination, in ascending order.
- After a programmable settle time per vector, it samples the function's single output and builds the full truth table in a register.
- Also counts the minterms (vectors with output 1).
- Sits in front of expression blocks such as std_exp and replaces hand-stepped benches with a start/busy/done-driven hardware sweep.

---
 rtl/truth_table_sequencer.sv | 144 ++++++++++++++
 tb/tb_truth_table_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sequencer.sv
// truth_table_sequencer
//
// Steps a combinational N_IN-input function through every input vector in
// ascending order. Each vector is held for SETTLE_CYCLES cycles and then
// sampled for one cycle. The function output is captured into a truth-table
// register, and the number of ones seen (minterms) is counted.
//
// Ports:
//   in_clk     system clock; all state changes on the rising edge
//   in_rst     synchronous, active-high reset
//   in_start   single-cycle request to begin a sweep
//   in_abort   cancels a sweep in progress
//   in_y       output of the function under test
//   out_vec    input vector driven to the function (MSB maps to in_a)
//   out_busy   high while a sweep is in progress
//   out_done   high from sweep completion until the next start or reset
//   out_table  captured truth table; bit[i] = in_y sampled with out_vec == i
//   out_count  number of 1 bits captured into out_table
//   dbg_state  current FSM state (IDLE=0, SETTLE=1, SAMPLE=2, DONE=3)
//
// Handshake: a start request is accepted on any edge where in_start=1,
// in_abort=0 and the block is not busy (IDLE or DONE). Requests made while
// busy are dropped rather than queued. out_busy rises on the accepting edge.
// out_busy falls and out_done rises together on the edge that captures the
// last vector. in_abort wins over in_start in the same cycle.

module truth_table_sequencer #(
    parameter int N_IN          = 3,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                 in_clk,
    input  logic                 in_rst,
    input  logic                 in_start,
    input  logic                 in_abort,
    input  logic                 in_y,
    output logic [N_IN-1:0]      out_vec,
    output logic                 out_busy,
    output logic                 out_done,
    output logic [2**N_IN-1:0]   out_table,
    output logic [N_IN:0]        out_count,
    output logic [1:0]           dbg_state
);

    localparam int DEPTH = 2**N_IN;
    localparam int CW    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [N_IN-1:0] LAST_VEC = N_IN'(DEPTH - 1);
    localparam logic [CW-1:0]   RELOAD   = CW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    // The vector register doubles as the table index. The two values are
    // always equal, so a separate index register would be redundant.
    logic [N_IN-1:0]     vec_q, vec_d;
    logic [DEPTH-1:0]    tab_q, tab_d;
    logic [N_IN:0]       count_q, count_d;

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            vec_q   <= '0;
            tab_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vec_q   <= vec_d;
            tab_q   <= tab_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        vec_d   = vec_q;
        tab_d   = tab_q;
        count_d = count_q;
        case (state_q)
            IDLE, DONE: begin
                if (in_start && !in_abort) begin
                    state_d = SETTLE;
                    cnt_d   = RELOAD;
                    vec_d   = '0;
                    tab_d   = '0;
                    count_d = '0;
                end
            end
            SETTLE: begin
                if (in_abort) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    vec_d   = '0;
                    tab_d   = '0;
                    count_d = '0;
                end else if (cnt_q == '0) begin
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            SAMPLE: begin
                // An abort in this cycle discards the pending sample,
                // including the one for the final vector.
                if (in_abort) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    vec_d   = '0;
                    tab_d   = '0;
                    count_d = '0;
                end else begin
                    tab_d[vec_q] = in_y;
                    count_d      = count_q + (N_IN + 1)'(in_y);
                    if (vec_q == LAST_VEC) begin
                        // Hold the last vector so the index never wraps.
                        state_d = DONE;
                    end else begin
                        state_d = SETTLE;
                        vec_d   = vec_q + N_IN'(1);
                        cnt_d   = RELOAD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Every output is decoded from registers only. No input reaches an
    // output without passing through a flop.
    assign out_vec   = vec_q;
    assign out_busy  = (state_q == SETTLE) || (state_q == SAMPLE);
    assign out_done  = (state_q == DONE);
    assign out_table = tab_q;
    assign out_count = count_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Testbench for truth_table_sequencer.
//
// Two instances are used: one with the default parameters and one with
// SETTLE_CYCLES=1. Each instance's in_y comes from a selectable reference
// function of its own out_vec.
//
// Inputs are driven on the falling edge of the clock. Outputs are sampled
// on the following falling edge.

module tb_truth_table_sequencer;

    localparam int M_STD  = 0;  // std_exp: y = a | (b & ~c)
    localparam int M_XOR  = 1;  // y = v[0] ^ v[1]
    localparam int M_ONE  = 2;
    localparam int M_ZERO = 3;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       start0 = 1'b0, abort0 = 1'b0, y0;
    logic       start1 = 1'b0, abort1 = 1'b0, y1;
    logic [2:0] vec0, vec1;
    logic       busy0, busy1, done0, done1;
    logic [7:0] tab0, tab1;
    logic [3:0] cnt0, cnt1;
    logic [1:0] st0, st1;

    int y_mode = M_STD;
    int sel    = 0;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic ref_fn(input int mode, input logic [2:0] v);
        case (mode)
            M_STD:   return v[2] | (v[1] & ~v[0]);
            M_XOR:   return v[0] ^ v[1];
            M_ONE:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    always_comb y0 = ref_fn(y_mode, vec0);
    always_comb y1 = ref_fn(y_mode, vec1);

    truth_table_sequencer dut0 (
        .in_clk(clk), .in_rst(rst), .in_start(start0), .in_abort(abort0),
        .in_y(y0), .out_vec(vec0), .out_busy(busy0), .out_done(done0),
        .out_table(tab0), .out_count(cnt0), .dbg_state(st0)
    );

    truth_table_sequencer #(.N_IN(3), .SETTLE_CYCLES(1)) dut1 (
        .in_clk(clk), .in_rst(rst), .in_start(start1), .in_abort(abort1),
        .in_y(y1), .out_vec(vec1), .out_busy(busy1), .out_done(done1),
        .out_table(tab1), .out_count(cnt1), .dbg_state(st1)
    );

    // view of the currently selected instance
    logic [2:0] vec_s;
    logic       busy_s, done_s;
    logic [7:0] tab_s;
    logic [3:0] cnt_s;
    always_comb begin
        vec_s  = (sel == 1) ? vec1  : vec0;
        busy_s = (sel == 1) ? busy1 : busy0;
        done_s = (sel == 1) ? done1 : done0;
        tab_s  = (sel == 1) ? tab1  : tab0;
        cnt_s  = (sel == 1) ? cnt1  : cnt0;
    end

    // scoreboard
    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic set_start(input logic v);
        if (sel == 1) start1 = v;
        else          start0 = v;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    typedef struct {
        int         sel;
        int         mode;
        logic [7:0] tab;
        int         count;
        int         cycles;   // edges from start acceptance to done
        int         poke;     // k at which in_start is held for 5 cycles, -1 none
    } vec_rec_t;

    vec_rec_t vecs[5];

    // Issues a start, follows the vector stepping, and checks the results.
    task automatic run_sweep(input vec_rec_t r);
        int k;
        int per;
        int ev;
        sel    = r.sel;
        y_mode = r.mode;
        per    = (r.sel == 1) ? 2 : 3;
        set_start(1'b1);
        step(1);
        set_start(1'b0);
        check("start_busy",  32'(busy_s), 32'd1);
        check("start_done",  32'(done_s), 32'd0);
        check("start_table", 32'(tab_s),  32'd0);
        check("start_count", 32'(cnt_s),  32'd0);
        k = 0;
        while (!done_s && k < 200) begin
            if (k % per == 0) begin
                ev = k / per;
                if (ev > 7) ev = 7;
                check("vec_step", 32'(vec_s), 32'(ev));
                check("busy_hold", 32'(busy_s), 32'd1);
            end
            set_start(r.poke >= 0 && k >= r.poke && k < r.poke + 5);
            step(1);
            k++;
        end
        set_start(1'b0);
        check("done_edge",  32'(k),      32'(r.cycles));
        check("done_table", 32'(tab_s),  32'(r.tab));
        check("done_count", 32'(cnt_s),  32'(r.count));
        check("done_busy",  32'(busy_s), 32'd0);
        check("done_vec",   32'(vec_s),  32'd7);
    endtask

    initial begin
        int seen;
        vecs[0] = '{sel: 0, mode: M_STD,  tab: 8'hF4, count: 5, cycles: 24, poke: -1};
        vecs[1] = '{sel: 0, mode: M_ONE,  tab: 8'hFF, count: 8, cycles: 24, poke: -1};
        vecs[2] = '{sel: 0, mode: M_STD,  tab: 8'hF4, count: 5, cycles: 24, poke: 5};
        vecs[3] = '{sel: 1, mode: M_XOR,  tab: 8'h66, count: 4, cycles: 16, poke: -1};
        vecs[4] = '{sel: 1, mode: M_ZERO, tab: 8'h00, count: 0, cycles: 16, poke: -1};

        // reset
        step(3);
        rst = 1'b0;
        step(1);
        check("rst_vec0",   32'(vec0),  32'd0);
        check("rst_busy0",  32'(busy0), 32'd0);
        check("rst_done0",  32'(done0), 32'd0);
        check("rst_table0", 32'(tab0),  32'd0);
        check("rst_count0", 32'(cnt0),  32'd0);
        check("rst_state0", 32'(st0),   32'd0);
        check("rst_busy1",  32'(busy1), 32'd0);
        check("rst_table1", 32'(tab1),  32'd0);

        // start + abort together in IDLE: abort wins
        start0 = 1'b1; abort0 = 1'b1;
        step(1);
        start0 = 1'b0; abort0 = 1'b0;
        check("idle_collide_busy",  32'(busy0), 32'd0);
        check("idle_collide_state", 32'(st0),   32'd0);
        step(2);
        check("idle_collide_done",  32'(done0), 32'd0);

        // table-driven sweeps, back-to-back on the same instance
        for (int i = 0; i < 5; i++) run_sweep(vecs[i]);

        // dut0 in DONE with F4: abort has no effect
        sel = 0;
        abort0 = 1'b1;
        step(1);
        abort0 = 1'b0;
        check("done_abort_done",  32'(done0), 32'd1);
        check("done_abort_table", 32'(tab0),  32'hF4);
        // start + abort in DONE: no new sweep
        start0 = 1'b1; abort0 = 1'b1;
        step(1);
        start0 = 1'b0; abort0 = 1'b0;
        check("done_collide_done",  32'(done0), 32'd1);
        check("done_collide_busy",  32'(busy0), 32'd0);
        check("done_collide_table", 32'(tab0),  32'hF4);
        check("done_collide_count", 32'(cnt0),  32'd5);

        // abort while out_vec == 3
        y_mode = M_STD;
        start0 = 1'b1;
        step(1);
        start0 = 1'b0;
        step(10);
        check("pre_abort_vec",   32'(vec0), 32'd3);
        check("pre_abort_table", 32'(tab0), 32'h04);
        check("pre_abort_count", 32'(cnt0), 32'd1);
        abort0 = 1'b1;
        step(1);
        abort0 = 1'b0;
        check("abort_state", 32'(st0),   32'd0);
        check("abort_vec",   32'(vec0),  32'd0);
        check("abort_table", 32'(tab0),  32'd0);
        check("abort_count", 32'(cnt0),  32'd0);
        check("abort_done",  32'(done0), 32'd0);
        check("abort_busy",  32'(busy0), 32'd0);
        run_sweep(vecs[0]);

        // abort during the final SAMPLE cycle discards the last sample
        start0 = 1'b1;
        step(1);
        start0 = 1'b0;
        step(23);
        check("last_sample_state", 32'(st0),  32'd2);
        check("last_sample_vec",   32'(vec0), 32'd7);
        abort0 = 1'b1;
        step(1);
        abort0 = 1'b0;
        check("last_abort_state", 32'(st0),   32'd0);
        check("last_abort_done",  32'(done0), 32'd0);
        check("last_abort_table", 32'(tab0),  32'd0);
        check("last_abort_count", 32'(cnt0),  32'd0);
        check("last_abort_vec",   32'(vec0),  32'd0);

        // reset while out_vec == 5
        start0 = 1'b1;
        step(1);
        start0 = 1'b0;
        step(15);
        check("pre_rst_vec", 32'(vec0), 32'd5);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("mid_rst_vec",   32'(vec0),  32'd0);
        check("mid_rst_busy",  32'(busy0), 32'd0);
        check("mid_rst_done",  32'(done0), 32'd0);
        check("mid_rst_table", 32'(tab0),  32'd0);
        check("mid_rst_count", 32'(cnt0),  32'd0);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            step(1);
            if (done0 || busy0) seen++;
        end
        check("mid_rst_quiet", 32'(seen), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
